// File: rtl/ps2_pkg.sv
// Shared constants, event layout and decoder state type for the PS/2 scan-code decoder.
// Contents: prefix bytes, device response codes, event field positions,
// decoder FSM state enum, pause-sequence skip length and small helpers.
package ps2_pkg;

  localparam int unsigned EVT_W       = 10;
  localparam int unsigned EVT_BRK_BIT = 9;
  localparam int unsigned EVT_EXT_BIT = 8;
  localparam int unsigned SKIP_W      = 3;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Bytes after the initial 0xE1 of the pause sequence minus the final one.
  localparam logic [SKIP_W-1:0] PAUSE_SKIP = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } dec_state_e;

  // Device response bytes: ack, BAT ok, echo, errors, resend.
  function automatic logic is_resp(logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [EVT_W-1:0] mk_evt(logic brk, logic ext, logic [7:0] code);
    return {brk, ext, code};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO with synchronous flush.
// Ports: clk, rst (async high), flush, push/din, pop/dout, full, empty,
// count (0..DEPTH), drop (pulse: push refused because full with no pop).
module ps2_evt_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop) && !flush;
  assign drop    = push && full && !do_pop && !flush;
  assign dout    = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: turns received set-2 bytes into make/break events
// ({break, extended, code}) queued in an event FIFO, and latches device responses.
// Ports: Bus2IP_Clk, reset (async high), flush, received_data/_en byte input,
// evt_pop/evt_valid/evt_data/evt_count FIFO head, overflow (sticky) + overflow_clr,
// resp_valid/resp_data last response byte.
// Build option: define PS2_REPEAT_FILTER_EN to suppress typematic repeat makes
// with a 512-entry pressed-key bitmap indexed {extended, code}.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       Bus2IP_Clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       evt_pop,
  output logic       evt_valid,
  output logic [9:0] evt_data,
  output logic [6:0] evt_count,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic       resp_valid,
  output logic [7:0] resp_data
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  dec_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              push_raw;
  logic              push;
  logic [EVT_W-1:0]  push_word;
  logic              resp_hit;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_drop;
  logic [CW-1:0]     fifo_count;

  // Decoder state register.
  always_ff @(posedge Bus2IP_Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state and event generation; only a byte strobe advances the FSM.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push_raw  = 1'b0;
    push_word = '0;
    resp_hit  = 1'b0;
    if (received_data_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (received_data == PFX_EXT) begin
            state_d = ST_EXT;
          end else if (received_data == PFX_BRK) begin
            state_d = ST_BRK;
          end else if (received_data == PFX_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (is_resp(received_data)) begin
            resp_hit = 1'b1;
          end else begin
            push_raw  = 1'b1;
            push_word = mk_evt(1'b0, 1'b0, received_data);
          end
        end
        ST_EXT: begin
          if (received_data == PFX_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            push_raw  = 1'b1;
            push_word = mk_evt(1'b0, 1'b1, received_data);
            state_d   = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_raw  = 1'b1;
          push_word = mk_evt(1'b1, 1'b0, received_data);
          state_d   = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push_raw  = 1'b1;
          push_word = mk_evt(1'b1, 1'b1, received_data);
          state_d   = ST_IDLE;
        end
        ST_PAUSE: begin
          // Pause bytes are swallowed whole; the last one emits the pause event.
          if (skip_q == '0) begin
            push_raw  = 1'b1;
            push_word = mk_evt(1'b0, 1'b1, PFX_PAUSE);
            state_d   = ST_IDLE;
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [511:0] pressed_q;
  logic [8:0]   key_idx;
  logic         is_pause;
  logic         is_brk;

  assign key_idx  = {push_word[EVT_EXT_BIT], push_word[7:0]};
  assign is_pause = (state_q == ST_PAUSE);
  assign is_brk   = push_word[EVT_BRK_BIT];
  assign push     = push_raw && (is_pause || is_brk || !pressed_q[key_idx]);

  // Pressed-key bitmap: make marks a key, break releases it.
  always_ff @(posedge Bus2IP_Clk or posedge reset) begin
    if (reset) begin
      pressed_q <= '0;
    end else if (flush) begin
      pressed_q <= '0;
    end else if (push_raw && !is_pause) begin
      pressed_q[key_idx] <= !is_brk;
    end
  end
`else
  assign push = push_raw;
`endif

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Bus2IP_Clk),
    .rst   (reset),
    .flush (flush),
    .push  (push),
    .din   (push_word),
    .pop   (evt_pop),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign evt_valid = !fifo_empty;
  assign evt_count = 7'(fifo_count);

  // Sticky overflow; a new drop outranks a same-cycle clear.
  always_ff @(posedge Bus2IP_Clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (flush)        overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  // Last device response byte.
  always_ff @(posedge Bus2IP_Clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (flush) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (resp_hit) begin
      resp_valid <= 1'b1;
      resp_data  <= received_data;
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed sequences plus random
// byte/pop/flush traffic compared every cycle against a byte-sequence model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       evt_pop;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic [6:0] evt_count;
  logic       overflow;
  logic       overflow_clr;
  logic       resp_valid;
  logic [7:0] resp_data;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .Bus2IP_Clk       (clk),
    .reset            (reset),
    .flush            (flush),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .evt_pop          (evt_pop),
    .evt_valid        (evt_valid),
    .evt_data         (evt_data),
    .evt_count        (evt_count),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: pending byte sequence, event queue, flags.
  logic [7:0] seq[$];
  logic [9:0] mq[$];
  bit         m_ovf;
  bit         m_rv;
  logic [7:0] m_rd;
`ifdef PS2_REPEAT_FILTER_EN
  bit         pressed[512];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit resp_byte(logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic void model_clear();
    seq.delete();
    mq.delete();
    m_ovf = 0;
    m_rv  = 0;
    m_rd  = 8'h00;
`ifdef PS2_REPEAT_FILTER_EN
    foreach (pressed[i]) pressed[i] = 0;
`endif
  endfunction

  // One clock edge of the reference, from the inputs sampled at that edge.
  function automatic void model_edge(bit en, logic [7:0] b, bit pop, bit fl, bit clr);
    bit         have = 0;
    bit         pause = 0;
    bit         brk = 0;
    bit         ext = 0;
    bit         popped;
    logic [9:0] e = '0;
    if (fl) begin
      seq.delete();
      mq.delete();
      m_ovf = 0;
      m_rv  = 0;
      m_rd  = 8'h00;
`ifdef PS2_REPEAT_FILTER_EN
      foreach (pressed[i]) pressed[i] = 0;
`endif
      return;
    end
    popped = pop && (mq.size() > 0);
    if (en) begin
      if (seq.size() > 0 && seq[0] == 8'hE1) begin
        seq.push_back(b);
        if (seq.size() == 8) begin
          have = 1; pause = 1; e = 10'h1E1;
          seq.delete();
        end
      end else if ((seq.size() == 0 && b inside {8'hE0, 8'hF0, 8'hE1}) ||
                   (seq.size() == 1 && seq[0] == 8'hE0 && b == 8'hF0)) begin
        seq.push_back(b);
      end else if (seq.size() == 0 && resp_byte(b)) begin
        m_rv = 1;
        m_rd = b;
      end else begin
        foreach (seq[i]) begin
          if (seq[i] == 8'hF0) brk = 1;
          if (seq[i] == 8'hE0) ext = 1;
        end
        have = 1;
        e = {brk, ext, b};
        seq.delete();
      end
    end
`ifdef PS2_REPEAT_FILTER_EN
    if (have && !pause) begin
      if (!brk && pressed[{ext, b}]) have = 0;
      else pressed[{ext, b}] = !brk;
    end
`endif
    if (popped) void'(mq.pop_front());
    if (clr) m_ovf = 0;
    if (have) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(e);
    end
  endfunction

  task automatic compare_all(input string ctx);
    check({ctx, ":evt_valid"}, 32'(evt_valid), 32'(mq.size() > 0));
    check({ctx, ":evt_count"}, 32'(evt_count), 32'(mq.size()));
    if (mq.size() > 0) check({ctx, ":evt_data"}, 32'(evt_data), 32'(mq[0]));
    check({ctx, ":overflow"}, 32'(overflow), 32'(m_ovf));
    check({ctx, ":resp_valid"}, 32'(resp_valid), 32'(m_rv));
    if (m_rv) check({ctx, ":resp_data"}, 32'(resp_data), 32'(m_rd));
  endtask

  task automatic step(input string ctx, input bit en, input logic [7:0] b,
                      input bit pop, input bit fl, input bit clr);
    @(negedge clk);
    received_data_en = en;
    received_data    = b;
    evt_pop          = pop;
    flush            = fl;
    overflow_clr     = clr;
    @(posedge clk);
    #1;
    model_edge(en, b, pop, fl, clr);
    compare_all(ctx);
    @(negedge clk);
    received_data_en = 0;
    evt_pop          = 0;
    flush            = 0;
    overflow_clr     = 0;
  endtask

  task automatic send(input string ctx, input logic [7:0] b);
    step(ctx, 1, b, 0, 0, 0);
  endtask

  task automatic pop_one(input string ctx);
    step(ctx, 0, 8'h00, 1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #12;
    model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  logic [7:0] pool [10];

  initial begin
    reset = 1; flush = 0; received_data = 8'h00; received_data_en = 0;
    evt_pop = 0; overflow_clr = 0;
    model_clear();
    #23;
    check("rst:evt_valid", 32'(evt_valid), 0);
    check("rst:evt_data", 32'(evt_data), 0);
    check("rst:evt_count", 32'(evt_count), 0);
    check("rst:overflow", 32'(overflow), 0);
    check("rst:resp_valid", 32'(resp_valid), 0);
    check("rst:resp_data", 32'(resp_data), 0);
    @(negedge clk);
    reset = 0;

    // Plain make then break.
    send("mk", 8'h1C);
    check("mk:latency", 32'(evt_data), 32'h01C);
    send("brk0", 8'hF0);
    send("brk1", 8'h1C);
    check("brk:count", 32'(evt_count), 2);
    pop_one("brk:pop");
    check("brk:head", 32'(evt_data), 32'h21C);
    pop_one("brk:pop2");
    pop_one("empty_pop");
    check("empty_pop:count", 32'(evt_count), 0);

    // Extended make/break and a response byte.
    send("e0", 8'hE0); send("e1", 8'h75);
    check("ext:mk", 32'(evt_data), 32'h175);
    send("e2", 8'hE0); send("e3", 8'hF0); send("e4", 8'h75);
    send("ack", 8'hFA);
    check("ack:resp", 32'(resp_data), 32'hFA);
    check("ack:count", 32'(evt_count), 2);
    pop_one("ext:pop");
    check("ext:brk", 32'(evt_data), 32'h375);
    pop_one("ext:pop2");

    // Pause sequence yields one event.
    send("p0", 8'hE1); send("p1", 8'h14); send("p2", 8'h77); send("p3", 8'hE1);
    send("p4", 8'hF0); send("p5", 8'h14); send("p6", 8'hF0);
    check("pause:pending", 32'(evt_count), 0);
    send("p7", 8'h77);
    check("pause:evt", 32'(evt_data), 32'h1E1);
    check("pause:count", 32'(evt_count), 1);
    pop_one("pause:pop");

    // Fill past depth, full push+pop, overflow clear and set-wins.
    for (int i = 0; i < DEPTH + 1; i++) send("fill", 8'(8'h10 + i));
    check("full:count", 32'(evt_count), DEPTH);
    check("full:ovf", 32'(overflow), 1);
    step("full:pushpop", 1, 8'h34, 1, 0, 0);
    check("full:pushpop_count", 32'(evt_count), DEPTH);
    step("ovf:setwins", 1, 8'h35, 0, 0, 1);
    check("ovf:setwins_v", 32'(overflow), 1);
    step("ovf:clr", 0, 8'h00, 0, 0, 1);
    check("ovf:clr_v", 32'(overflow), 0);
    step("flush_full", 0, 8'h00, 0, 1, 0);

    // Reset mid-prefix, then flush with queued events.
    send("rp0", 8'hE0);
    do_reset();
    send("rp1", 8'h1C);
    check("rp:evt", 32'(evt_data), 32'h01C);
    send("q1", 8'h15); send("q2", 8'h16);
    check("q:count", 32'(evt_count), 3);
    step("flush_q", 1, 8'h1D, 0, 1, 0);
    check("flush:valid", 32'(evt_valid), 0);
    check("flush:resp", 32'(resp_valid), 0);

    // Typematic repeat.
    send("tr0", 8'h1C); send("tr1", 8'h1C); send("tr2", 8'h1C);
    send("tr3", 8'hF0); send("tr4", 8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
    check("repeat:count", 32'(evt_count), 2);
`else
    check("repeat:count", 32'(evt_count), 4);
`endif
    step("flush_tr", 0, 8'h00, 0, 1, 0);

    // Random traffic.
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'hE1; pool[3] = 8'hFA;
    pool[4] = 8'hAA; pool[5] = 8'h1C; pool[6] = 8'h14; pool[7] = 8'h77;
    pool[8] = 8'h75; pool[9] = 8'h29;
    for (int c = 0; c < 4000; c++) begin
      bit         en;
      bit         pop;
      bit         fl;
      bit         clr;
      logic [7:0] b;
      en  = ($urandom_range(0, 2) == 0);
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      pop = (c % 1000 < 500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      fl  = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 49) == 0);
      step("rand", en, b, pop, fl, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16, event FIFO depth (power of two, 4..64).
REQ-002 SHALL provide port Bus2IP_Clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port flush  input  1  synchronous clear of FIFO, decoder state and flags (driven high while PS/2 disabled).
REQ-005 SHALL provide port received_data  input  8  byte from PS/2 receiver.
REQ-006 SHALL provide port received_data_en  input  1  one-cycle strobe qualifying received_data.
REQ-007 SHALL provide port evt_pop  input  1  consume head event.
REQ-008 SHALL provide port evt_valid  output  1  FIFO non-empty.
REQ-009 SHALL provide port evt_data  output  10  head event: [9]=break, [8]=extended, [7:0]=code.
REQ-010 SHALL provide port evt_count  output  7  current FIFO occupancy.
REQ-011 SHALL provide port overflow  output  1  sticky: event dropped because FIFO full.
REQ-012 SHALL provide port overflow_clr  input  1  clears overflow.
REQ-013 SHALL provide ports resp_valid (output 1) and resp_data (output 8): last device response byte, valid until next response or flush.

Function
REQ-014 SHALL run decoder FSM states IDLE, EXT, BRK, EXT_BRK, PAUSE; advance only on received_data_en.
REQ-015 IDLE: 0xE0->EXT; 0xF0->BRK; 0xE1->PAUSE with skip counter=6; response byte (0x00,0xAA,0xEE,0xFA,0xFC,0xFE,0xFF)->latch resp_data, set resp_valid, stay IDLE; other byte->push {0,0,byte}.
REQ-016 EXT: 0xF0->EXT_BRK; else push {0,1,byte}, ->IDLE. BRK: push {1,0,byte}, ->IDLE. EXT_BRK: push {1,1,byte}, ->IDLE.
REQ-017 PAUSE: each byte decrements counter; at counter 0 push {0,1,0xE1}, ->IDLE; bytes inside PAUSE never treated as prefixes or responses.
REQ-018 Event SHALL be visible on evt_valid/evt_data the cycle after the completing byte strobe (one-cycle latency).
REQ-019 FIFO SHALL be first-word fall-through; evt_data undefined-but-stable when evt_valid=0.
REQ-020 evt_pop while empty SHALL be ignored; count never underflows.
REQ-021 Push while full without simultaneous pop SHALL drop the event and set overflow; push+pop same cycle when full SHALL succeed, count unchanged.
REQ-022 Read/write pointers SHALL be log2(FIFO_DEPTH) bits, wrapping modulo depth; count width covers 0..FIFO_DEPTH.
REQ-023 overflow set and overflow_clr same cycle SHALL leave overflow=1.
REQ-024 flush SHALL have priority over push, pop and FSM advance; byte strobed during flush discarded.

Reset
REQ-025 reset SHALL force: FSM=IDLE, pointers/count=0, evt_valid=0, evt_data=0, overflow=0, resp_valid=0, resp_data=0, skip counter=0, filter bitmap clear.
REQ-026 reset asserted mid-sequence (e.g. after 0xE0) SHALL discard the partial prefix; next byte decoded from IDLE.

Configuration
REQ-027 With PS2_REPEAT_FILTER_EN defined, a 512-bit pressed bitmap indexed {extended,code} SHALL drop make events for keys already marked pressed, set the bit on accepted make, clear it on break; flush/reset clear it; pause event unfiltered.
REQ-028 Without PS2_REPEAT_FILTER_EN, every typematic make SHALL be pushed and no bitmap synthesized.

Structure
REQ-029 Package ps2_pkg SHALL hold: prefix constants (0xE0,0xF0,0xE1), response-code list, event field bit positions, FSM state enum, pause skip length.
REQ-030 FIFO SHALL be sub-module ps2_evt_fifo (parameterised width/depth, push/pop/full/empty/count, flush).

Verification
REQ-031 Bytes 0x1C, 0xF0, 0x1C -> events 0x01C then 0x21C; evt_count=2.
REQ-032 Bytes 0xE0,0x75,0xE0,0xF0,0x75 -> events 0x175, 0x375; byte 0xFA -> resp_valid=1, resp_data=0xFA, no event.
REQ-033 Bytes E1 14 77 E1 F0 14 F0 77 -> single event 0x1E1; no prefix misdecode.
REQ-034 17 make codes, no pop, depth 16 -> evt_count=16, overflow=1; pop+push when full -> count stays 16; overflow_clr -> 0.
REQ-035 0xE0 then reset, then 0x1C -> event 0x01C; flush with 3 queued -> evt_valid=0 next cycle.
REQ-036 PS2_REPEAT_FILTER_EN: 0x1C x3, F0 1C -> events 0x01C, 0x21C only; without macro -> 4 events.
